// File: rtl/testvector_sequencer.sv
// Steps through a synchronous vector ROM, drives each stimulus into a DUT, and scores the DUT response.
// Each vector takes 3+DUT_LAT cycles; start is ignored unless the sequencer is idle or done.
module testvector_sequencer #(
  parameter int N_VECTORS = 16,
  parameter int IN_W      = 8,
  parameter int OUT_W     = 8,
  parameter int DUT_LAT   = 0,
  localparam int ADDR_W   = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [ADDR_W-1:0]       vec_addr,
  input  logic [IN_W+OUT_W-1:0]   vec_data,
  output logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [31:0]             error_count,
  output logic [ADDR_W-1:0]       first_fail
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, CHECK, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_VECTORS - 1);
  localparam logic [3:0]        LAT      = 4'(DUT_LAT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [IN_W-1:0]     dut_in_q, dut_in_d;
  logic [OUT_W-1:0]    expected_q, expected_d;
  logic [31:0]         error_count_q, error_count_d;
  logic [ADDR_W-1:0]   first_fail_q, first_fail_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      index_q       <= '0;
      wait_cnt_q    <= '0;
      dut_in_q      <= '0;
      expected_q    <= '0;
      error_count_q <= '0;
      first_fail_q  <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      wait_cnt_q    <= wait_cnt_d;
      dut_in_q      <= dut_in_d;
      expected_q    <= expected_d;
      error_count_q <= error_count_d;
      first_fail_q  <= first_fail_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    wait_cnt_d    = wait_cnt_q;
    dut_in_d      = dut_in_q;
    expected_d    = expected_q;
    error_count_d = error_count_q;
    first_fail_d  = first_fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          index_d       = '0;
          error_count_d = '0;
          first_fail_d  = '0;
          state_d       = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        dut_in_d   = vec_data[IN_W+OUT_W-1:OUT_W];
        expected_d = vec_data[OUT_W-1:0];
        wait_cnt_d = LAT;
        state_d    = (DUT_LAT > 0) ? WAIT : CHECK;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = CHECK;
      end
      CHECK: begin
        if (dut_out != expected_q) begin
          // first_fail latches only on the transition out of a clean run
          if (error_count_q == '0) first_fail_d = index_q;
          if (error_count_q != '1) error_count_d = error_count_q + 32'd1;
        end
        if (index_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE) && (state_q != DONE);
    done        = (state_q == DONE);
    pass        = done && (error_count_q == '0);
    vec_addr    = index_q;
    dut_in      = dut_in_q;
    error_count = error_count_q;
    first_fail  = first_fail_q;
  end

endmodule

// File: tb/tb_testvector_sequencer.sv
// Runs two sequencer instances (DUT_LAT=0 and DUT_LAT=2) against a looped-back DUT and shared ROM contents.
module tb_testvector_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] addr_a, addr_b, ff_a, ff_b;
  logic [7:0] data_a, data_b;
  logic [3:0] din_a, din_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [31:0] err_a, err_b;
  logic [3:0] rom_exp [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  testvector_sequencer #(.N_VECTORS(4), .IN_W(4), .OUT_W(4), .DUT_LAT(0)) u_a (
    .clk(clk), .reset(rst), .start(start), .vec_addr(addr_a), .vec_data(data_a),
    .dut_in(din_a), .dut_out(din_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .error_count(err_a), .first_fail(ff_a));

  testvector_sequencer #(.N_VECTORS(4), .IN_W(4), .OUT_W(4), .DUT_LAT(2)) u_b (
    .clk(clk), .reset(rst), .start(start), .vec_addr(addr_b), .vec_data(data_b),
    .dut_in(din_b), .dut_out(din_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .error_count(err_b), .first_fail(ff_b));

  // Synchronous ROMs: stimulus is the address, expected value comes from rom_exp
  always @(posedge clk) begin
    data_a <= {2'b00, addr_a, rom_exp[addr_a]};
    data_b <= {2'b00, addr_b, rom_exp[addr_b]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] exp2;
    logic [3:0] exp3;
    int         pulse_at;
    int         exp_err;
    int         exp_ff;
    bit         exp_pass;
  } run_t;

  run_t runs [4];

  task automatic do_run(input run_t r, input int idx);
    int cyc_a = 0;
    int cyc_b = 0;
    rom_exp[0] = 4'h0; rom_exp[1] = 4'h1; rom_exp[2] = r.exp2; rom_exp[3] = r.exp3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("run%0d err_clear_a", idx), err_a, 0);
    check($sformatf("run%0d busy_a", idx), {31'd0, busy_a}, 1);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (cyc_a == 0 && done_a) cyc_a = c;
      if (cyc_b == 0 && done_b) cyc_b = c;
      start = (c == r.pulse_at);
      if (cyc_a != 0 && cyc_b != 0) break;
    end
    start = 1'b0;
    check($sformatf("run%0d cycles_a", idx), cyc_a, 12);
    check($sformatf("run%0d cycles_b", idx), cyc_b, 20);
    check($sformatf("run%0d err_a", idx), err_a, r.exp_err);
    check($sformatf("run%0d err_b", idx), err_b, r.exp_err);
    check($sformatf("run%0d pass_a", idx), {31'd0, pass_a}, {31'd0, r.exp_pass});
    check($sformatf("run%0d pass_b", idx), {31'd0, pass_b}, {31'd0, r.exp_pass});
    if (r.exp_err != 0) begin
      check($sformatf("run%0d ff_a", idx), {30'd0, ff_a}, r.exp_ff);
      check($sformatf("run%0d ff_b", idx), {30'd0, ff_b}, r.exp_ff);
    end
  endtask

  initial begin
    runs[0] = '{exp2: 4'h2, exp3: 4'h3, pulse_at: 0, exp_err: 0, exp_ff: 0, exp_pass: 1'b1};
    runs[1] = '{exp2: 4'hF, exp3: 4'h0, pulse_at: 0, exp_err: 2, exp_ff: 2, exp_pass: 1'b0};
    runs[2] = '{exp2: 4'h2, exp3: 4'h3, pulse_at: 0, exp_err: 0, exp_ff: 0, exp_pass: 1'b1};
    // Start pulse lands while instance A is in CHECK of vector 0
    runs[3] = '{exp2: 4'h2, exp3: 4'h3, pulse_at: 2, exp_err: 0, exp_ff: 0, exp_pass: 1'b1};
    rom_exp[0] = 4'h0; rom_exp[1] = 4'h1; rom_exp[2] = 4'h2; rom_exp[3] = 4'h3;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset busy", {31'd0, busy_a}, 0);
    check("reset done", {31'd0, done_a}, 0);
    check("reset pass", {31'd0, pass_a}, 0);
    check("reset err", err_a, 0);
    check("reset dut_in", {28'd0, din_a}, 0);
    repeat (3) @(posedge clk);
    #1 check("idle without start", {31'd0, busy_a | done_a}, 0);

    for (int i = 0; i < 4; i++) do_run(runs[i], i);

    // DONE holds its results and the last stimulus
    repeat (5) @(posedge clk);
    #1;
    check("done hold", {31'd0, done_a}, 1);
    check("done pass hold", {31'd0, pass_a}, 1);
    check("done dut_in hold", {28'd0, din_a}, 3);
    check("done vec_addr", {30'd0, addr_a}, 3);

    // Reset in WAIT of vector 1 on the DUT_LAT=2 instance
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("wait v1 dut_in_b", {28'd0, din_b}, 1);
    check("wait v1 busy_b", {31'd0, busy_b}, 1);
    #2 rst = 1'b1;
    #1;
    check("midrun rst busy_b", {31'd0, busy_b}, 0);
    check("midrun rst dut_in_b", {28'd0, din_b}, 0);
    check("midrun rst vec_addr_b", {30'd0, addr_b}, 0);
    check("midrun rst err_b", err_b, 0);
    check("midrun rst done_a", {31'd0, done_a}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("post rst idle", {31'd0, busy_b | done_b}, 0);
    do_run(runs[0], 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/testvector_sequencer.md
TESTVECTOR_SEQUENCER -- requirements
Module: testvector_sequencer

Interface
REQ-001 SHALL have parameter N_VECTORS, default 16: number of test vectors, at least 1.
REQ-002 SHALL have parameter IN_W, default 8: DUT input field width.
REQ-003 SHALL have parameter OUT_W, default 8: DUT expected/observed output width.
REQ-004 SHALL have parameter DUT_LAT, default 0: extra wait cycles before sampling the DUT, range 0..15.
REQ-005 SHALL have derived localparam ADDR_W = max(1, clog2(N_VECTORS)).
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-010 vec_addr  out  ADDR_W  vector ROM address.
REQ-011 vec_data  in  IN_W+OUT_W  ROM word {input, expected}; valid 1 cycle after vec_addr (synchronous ROM).
REQ-012 dut_in  out  IN_W  registered stimulus to the DUT.
REQ-013 dut_out  in  OUT_W  DUT response.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  high while in DONE.
REQ-016 pass  out  1  done AND error_count==0.
REQ-017 error_count  out  32  mismatch count, saturating at 2^32-1.
REQ-018 first_fail  out  ADDR_W  index of the first mismatching vector; valid when error_count!=0.

Function
REQ-019 SHALL implement the FSM IDLE, FETCH, LOAD, WAIT, CHECK, DONE, plus an index register (ADDR_W) and a wait counter (4 bits).
REQ-020 IDLE/DONE with start=1: index<=0, error_count<=0, first_fail<=0, next state FETCH; start in any other state SHALL be ignored.
REQ-021 FETCH, 1 cycle: vec_addr=index; next state LOAD.
REQ-022 LOAD, 1 cycle: dut_in<=vec_data[IN_W+OUT_W-1:OUT_W]; expected register<=vec_data[OUT_W-1:0]; wait counter<=DUT_LAT; next state WAIT if DUT_LAT>0, else CHECK.
REQ-023 WAIT: decrement the wait counter each cycle; go to CHECK in the cycle it reaches 1 (WAIT lasts exactly DUT_LAT cycles).
REQ-024 CHECK, 1 cycle: compare dut_out with the expected register; on mismatch increment error_count (saturating) and, if error_count was 0, set first_fail<=index.
REQ-025 CHECK exit: if index==N_VECTORS-1 go to DONE, else index<=index+1 and go to FETCH; index SHALL never wrap.
REQ-026 Each vector SHALL take exactly 3+DUT_LAT cycles; a full run SHALL take N_VECTORS*(3+DUT_LAT) cycles from the first FETCH to DONE entry.
REQ-027 vec_addr SHALL equal index in all states.
REQ-028 dut_in SHALL hold its last value in DONE and IDLE.
REQ-029 DONE SHALL hold done=1 and keep error_count, first_fail and pass stable until reset or start.

Reset
REQ-030 Reset SHALL force IDLE, index=0, wait counter=0, dut_in=0, expected=0, error_count=0, first_fail=0, busy=0, done=0 and pass=0, at any time including mid-run.
REQ-031 After reset deassertion, the block SHALL stay in IDLE until a start pulse.

Verification
REQ-032 N_VECTORS=4, IN_W=OUT_W=4, DUT_LAT=0, DUT wired dut_out=dut_in, ROM {i,i} for i=0..3; start -> done rises 12 cycles after the first FETCH, error_count=0, pass=1.
REQ-033 Same setup, but vector 2 expected=4'hF and vector 3 expected=4'h0 (observed 4'h3) -> error_count=2, first_fail=2, pass=0.
REQ-034 DUT_LAT=2 and the same vectors as REQ-032 -> each vector takes 5 cycles, done after 20 cycles, pass=1.
REQ-035 Assert reset during WAIT of vector 1 -> all outputs return to their reset values immediately; a new start completes a clean run.
REQ-036 Pulse start during CHECK of vector 0 -> run unaffected, still 12 cycles; start in DONE after the REQ-033 run with corrected ROM -> error_count clears to 0 and the run ends with pass=1.
